// File: rtl/zamanlayici_cevre.sv
// Memory-mapped timer: prescaled 32-bit counter with compare, match/overflow status and level interrupt.
// Bus port mirrors anabellek: combinational read, write committed on the rising edge.
module zamanlayici_cevre #(
   parameter int                    ADRES_BIT    = 32,
   parameter logic [ADRES_BIT-1:0]  TABAN_ADRES  = 32'h4000_0000,
   parameter int                    VERI_BIT     = 32,
   parameter int                    ONBOLUCU_BIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADRES_BIT-1:0] adres,
   output logic [VERI_BIT-1:0]  oku_veri,
   input  logic [VERI_BIT-1:0]  yaz_veri,
   input  logic                 yaz_gecerli,
   output logic                 secili,
   output logic                 kesme
);

   logic [VERI_BIT-1:0]     sayac_reg, sayac_next;
   logic [VERI_BIT-1:0]     karsilastirma_reg, karsilastirma_next;
   logic [2:0]              denetim_reg, denetim_next;
   logic [1:0]              durum_reg, durum_next;
   logic [ONBOLUCU_BIT-1:0] onbolucu_reg, onbolucu_next;
   logic [ONBOLUCU_BIT-1:0] pc_reg, pc_next;

   logic [ADRES_BIT-1:0] fark;
   logic [2:0]           ofs;
   logic                 yaz;
   logic                 tick, esit, eslesme_set, tasma_set;

   // Subtracting first keeps the upper window bound free of overflow at the top of the address space.
   assign fark   = adres - TABAN_ADRES;
   assign secili = (adres >= TABAN_ADRES) && (fark < ADRES_BIT'(32));
   assign ofs    = fark[4:2];
   assign yaz    = yaz_gecerli & secili;
   assign kesme  = durum_reg[0] & denetim_reg[2];

   always_comb begin
      oku_veri = '0;
      if (secili) begin
         case (ofs)
            3'd0:    oku_veri = sayac_reg;
            3'd1:    oku_veri = karsilastirma_reg;
            3'd2:    oku_veri = {{(VERI_BIT-3){1'b0}}, denetim_reg};
            3'd3:    oku_veri = {{(VERI_BIT-2){1'b0}}, durum_reg};
            3'd4:    oku_veri = {{(VERI_BIT-ONBOLUCU_BIT){1'b0}}, onbolucu_reg};
            default: oku_veri = '0;
         endcase
      end
   end

   always_comb begin
      tick               = denetim_reg[0] && (pc_reg == onbolucu_reg);
      esit               = (sayac_reg == karsilastirma_reg);
      eslesme_set        = tick && esit;
      tasma_set          = tick && !esit && (sayac_reg == '1);
      sayac_next         = sayac_reg;
      karsilastirma_next = karsilastirma_reg;
      denetim_next       = denetim_reg;
      onbolucu_next      = onbolucu_reg;
      durum_next         = durum_reg;
      pc_next            = pc_reg + ONBOLUCU_BIT'(1);

      if (!denetim_reg[0] || tick || (yaz && (ofs == 3'd2 || ofs == 3'd4)))
         pc_next = '0;

      if (tick) begin
         if (esit && denetim_reg[1])
            sayac_next = '0;
         else if (tasma_set)
            sayac_next = '0;
         else
            sayac_next = sayac_reg + VERI_BIT'(1);
      end

      if (yaz) begin
         case (ofs)
            3'd0:    sayac_next         = yaz_veri;
            3'd1:    karsilastirma_next = yaz_veri;
            3'd2:    denetim_next       = yaz_veri[2:0];
            3'd3:    durum_next         = durum_reg & ~yaz_veri[1:0];
            3'd4:    onbolucu_next      = yaz_veri[ONBOLUCU_BIT-1:0];
            default: ;
         endcase
      end

      // Hardware set wins over a same-cycle write-1-to-clear.
      durum_next = durum_next | {tasma_set, eslesme_set};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sayac_reg         <= '0;
         karsilastirma_reg <= '1;
         denetim_reg       <= '0;
         durum_reg         <= '0;
         onbolucu_reg      <= '0;
         pc_reg            <= '0;
      end else begin
         sayac_reg         <= sayac_next;
         karsilastirma_reg <= karsilastirma_next;
         denetim_reg       <= denetim_next;
         durum_reg         <= durum_next;
         onbolucu_reg      <= onbolucu_next;
         pc_reg            <= pc_next;
      end
   end

endmodule

// File: tb/tb_zamanlayici_cevre.sv
// Scoreboard bench for zamanlayici_cevre: stimulus queues expected read results, a negedge monitor checks them.
module tb_zamanlayici_cevre;

   localparam logic [31:0] TABAN = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adres = TABAN;
   logic [31:0] yaz_veri = '0;
   logic        yaz_gecerli = 1'b0;
   logic [31:0] oku_veri;
   logic        secili;
   logic        kesme;

   zamanlayici_cevre dut (
      .clk         (clk),
      .rst         (rst),
      .adres       (adres),
      .oku_veri    (oku_veri),
      .yaz_veri    (yaz_veri),
      .yaz_gecerli (yaz_gecerli),
      .secili      (secili),
      .kesme       (kesme)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       ad;
      logic [31:0] veri;
      logic        kes_chk;
      logic        kes;
      logic        sec_chk;
      logic        sec;
   } bek_t;

   bek_t kuyruk[$];
   bek_t mon_b;
   logic izle = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Monitor: one queued expectation per strobed read cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (izle) begin
         checks++;
         if (kuyruk.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: read strobe with no expectation, adres=%h", adres);
         end else begin
            mon_b = kuyruk.pop_front();
            $display("txn read %s adres=%h oku_veri=%h exp=%h secili=%b kesme=%b",
                     mon_b.ad, adres, oku_veri, mon_b.veri, secili, kesme);
            if (oku_veri !== mon_b.veri) begin
               failures++;
               $display("FAIL %s: oku_veri=%h required=%h", mon_b.ad, oku_veri, mon_b.veri);
            end
            if (mon_b.kes_chk) begin
               checks++;
               if (kesme !== mon_b.kes) begin
                  failures++;
                  $display("FAIL %s_kesme: kesme=%b required=%b", mon_b.ad, kesme, mon_b.kes);
               end
            end
            if (mon_b.sec_chk) begin
               checks++;
               if (secili !== mon_b.sec) begin
                  failures++;
                  $display("FAIL %s_secili: secili=%b required=%b", mon_b.ad, secili, mon_b.sec);
               end
            end
         end
      end
   end

   task automatic yaz(input logic [31:0] a, input logic [31:0] d);
      adres       = a;
      yaz_veri    = d;
      yaz_gecerli = 1'b1;
      @(posedge clk);
      #1;
      yaz_gecerli = 1'b0;
      $display("txn write adres=%h veri=%h", a, d);
   endtask

   task automatic oku(input logic [31:0] a, input logic [31:0] e, input string ad,
                      input logic kc, input logic k, input logic sc, input logic s);
      bek_t b;
      b.ad = ad; b.veri = e; b.kes_chk = kc; b.kes = k; b.sec_chk = sc; b.sec = s;
      kuyruk.push_back(b);
      adres = a;
      izle  = 1'b1;
      @(posedge clk);
      #1;
      izle  = 1'b0;
   endtask

   task automatic okur(input logic [31:0] o, input logic [31:0] e, input string ad);
      oku(TABAN + o, e, ad, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic okk(input logic [31:0] o, input logic [31:0] e, input string ad, input logic k);
      oku(TABAN + o, e, ad, 1'b1, k, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values and window decode
      oku(TABAN,            32'h0,         "rst_sayac", 1'b1, 1'b0, 1'b1, 1'b1);
      okur(32'h04, 32'hFFFF_FFFF, "rst_karsilastirma");
      okur(32'h08, 32'h0,         "rst_denetim");
      okur(32'h0C, 32'h0,         "rst_durum");
      okur(32'h10, 32'h0,         "rst_onbolucu");
      oku(32'h8000_0000,    32'h0,         "disari",    1'b0, 1'b0, 1'b1, 1'b0);
      oku(TABAN + 32'h1C,   32'h0,         "bos_1c",    1'b0, 1'b0, 1'b1, 1'b1);
      oku(TABAN + 32'h20,   32'h0,         "ust_sinir", 1'b0, 1'b0, 1'b1, 1'b0);
      oku(TABAN - 32'h4,    32'h0,         "alt_sinir", 1'b0, 1'b0, 1'b1, 1'b0);

      // Writes outside the window or to reserved offsets have no effect
      yaz(TABAN + 32'h20, 32'h55);
      yaz(TABAN + 32'h14, 32'h77);
      okur(32'h00, 32'h0, "disari_yaz");
      okur(32'h14, 32'h0, "bos_14");
      yaz(TABAN + 32'h08, 32'hFFFF_FFF8);
      okur(32'h08, 32'h0, "denetim_maske");

      // Free running, tick every cycle
      yaz(TABAN + 32'h10, 32'h0);
      yaz(TABAN + 32'h08, 32'h1);
      for (int i = 0; i <= 10; i++) okur(32'h00, 32'(i), "serbest");
      yaz(TABAN + 32'h08, 32'h0);
      yaz(TABAN + 32'h00, 32'h0);
      okur(32'h00, 32'h0, "durdur");

      // Prescaler 3: one increment per four cycles
      yaz(TABAN + 32'h10, 32'h1234_5603);
      okur(32'h10, 32'h3, "onb_maske");
      yaz(TABAN + 32'h08, 32'h1);
      for (int k = 0; k <= 12; k++) okur(32'h00, 32'(k / 4), "onbolucu");
      yaz(TABAN + 32'h08, 32'h0);
      yaz(TABAN + 32'h00, 32'h0);
      yaz(TABAN + 32'h10, 32'h0);

      // Auto-reload with interrupt
      yaz(TABAN + 32'h04, 32'h5);
      yaz(TABAN + 32'h08, 32'h7);
      for (int k = 0; k <= 7; k++)
         okk(32'h00, (k <= 5) ? 32'(k) : 32'(k - 6), "oto", (k >= 6));
      yaz(TABAN + 32'h0C, 32'h1);
      okk(32'h0C, 32'h0, "w1c", 1'b0);
      okk(32'h00, 32'h4, "oto_bekle", 1'b0);
      yaz(TABAN + 32'h0C, 32'h1);
      okk(32'h0C, 32'h1, "w1c_cakisma", 1'b1);
      okk(32'h00, 32'h1, "oto_sonra", 1'b1);
      yaz(TABAN + 32'h08, 32'h0);
      yaz(TABAN + 32'h0C, 32'h3);
      okk(32'h0C, 32'h0, "durum_temiz", 1'b0);

      // Overflow followed by a match at zero
      yaz(TABAN + 32'h00, 32'hFFFF_FFFE);
      yaz(TABAN + 32'h04, 32'h0);
      yaz(TABAN + 32'h08, 32'h1);
      okur(32'h00, 32'hFFFF_FFFE, "tasma_0");
      okur(32'h00, 32'hFFFF_FFFF, "tasma_1");
      okk(32'h0C, 32'h2, "tasma", 1'b0);
      okur(32'h00, 32'h1, "tasma_sonra");
      okk(32'h0C, 32'h3, "tasma_eslesme", 1'b0);

      // Bus write collides with a tick
      yaz(TABAN + 32'h00, 32'h100);
      okur(32'h00, 32'h100, "yaz_cakisma");
      okur(32'h00, 32'h101, "yaz_cakisma_sonra");
      yaz(TABAN + 32'h10, 32'h5);

      // Reset mid-count, overriding a concurrent write
      adres       = TABAN + 32'h04;
      yaz_veri    = 32'h7;
      yaz_gecerli = 1'b1;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      yaz_gecerli = 1'b0;
      $display("txn reset with write adres=%h veri=%h", TABAN + 32'h04, 32'h7);
      okk(32'h00, 32'h0,         "rst2_sayac", 1'b0);
      okur(32'h04, 32'hFFFF_FFFF, "rst2_karsilastirma");
      okur(32'h08, 32'h0,         "rst2_denetim");
      okur(32'h0C, 32'h0,         "rst2_durum");
      okur(32'h10, 32'h0,         "rst2_onbolucu");
      okur(32'h00, 32'h0,         "rst2_durgun");

      @(posedge clk);
      #1;
      checks++;
      if (kuyruk.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover: pending=%0d required=0", kuyruk.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
